// File: rtl/timers_pkg.sv
// Shared definitions for the timer interrupt controller.
//   irq_state_t : request FSM states (IDLE, REQ, SVC)
//   VEC_*       : encoding of the requested source on vector_o
//   vec_pending : returns the pending bit of the source named by a vector
package timers_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } irq_state_t;

  localparam logic [1:0] VEC_NONE = 2'b00;
  localparam logic [1:0] VEC_TF0  = 2'b01;
  localparam logic [1:0] VEC_TF1  = 2'b10;
  localparam logic [1:0] VEC_TF2  = 2'b11;

  function automatic logic vec_pending(input logic [1:0] vec, input logic [2:0] pend);
    logic hit;
    case (vec)
      VEC_TF0: hit = pend[0];
      VEC_TF1: hit = pend[1];
      VEC_TF2: hit = pend[2];
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/timers_irq_prio_enc.sv
// Combinational priority selector for the three timer interrupt sources.
// Ports:
//   pend   [2:0] in  pending bits, index 0 = TF0, 1 = TF1, 2 = TF2
//   prio   [2:0] in  priority bits, 1 = high, same indexing
//   valid        out at least one source pending
//   vector [1:0] out selected source (VEC_NONE when nothing pending)
module timers_irq_prio_enc
  import timers_pkg::*;
(
  input  logic [2:0] pend,
  input  logic [2:0] prio,
  output logic       valid,
  output logic [1:0] vector
);

  logic [2:0] high;
  logic [2:0] cand;

  always_comb begin
    high  = pend & prio;
    // High-priority sources shadow low ones; otherwise all pending compete.
    cand  = (|high) ? high : pend;
    valid = |pend;
    if (cand[0])      vector = VEC_TF0;
    else if (cand[1]) vector = VEC_TF1;
    else if (cand[2]) vector = VEC_TF2;
    else              vector = VEC_NONE;
  end

endmodule

// File: rtl/timers_irq_ctrl.sv
// Timer interrupt controller: holds the TF0/TF1/TF2 overflow flags, arbitrates
// pending sources on machine-cycle ticks and runs the request/service handshake
// with the core.
// Ports:
//   timers_irq_ctrl_clock_i          system clock (rising edge)
//   timers_irq_ctrl_reset_i          asynchronous active-low reset
//   timers_irq_ctrl_machine_cycle_i  machine-cycle level; 0->1 is a tick
//   timers_irq_ctrl_tf{0,1,2}_set_i  one-clock timer overflow pulses
//   timers_irq_ctrl_sfr_wr_tcon_i    software write strobe for TF0/TF1
//   timers_irq_ctrl_sfr_wr_tcon2_i   software write strobe for TF2
//   timers_irq_ctrl_sfr_tf{0,1,2}_i  software write data
//   timers_irq_ctrl_ea_i / et{0,1,2} global / per-source enables
//   timers_irq_ctrl_pt{0,1,2}_i      per-source priority, 1 = high
//   timers_irq_ctrl_ack_i            core accepts the request
//   timers_irq_ctrl_reti_i           core executed RETI
//   timers_irq_ctrl_tf{0,1,2}_o      flag values
//   timers_irq_ctrl_irq_req_o        interrupt request
//   timers_irq_ctrl_vector_o         requested source (00 none, 01/10/11 TF0/1/2)
//   timers_irq_ctrl_in_service_o     timer interrupt in service
module timers_irq_ctrl
  import timers_pkg::*;
(
  input  logic       timers_irq_ctrl_clock_i,
  input  logic       timers_irq_ctrl_reset_i,
  input  logic       timers_irq_ctrl_machine_cycle_i,
  input  logic       timers_irq_ctrl_tf0_set_i,
  input  logic       timers_irq_ctrl_tf1_set_i,
  input  logic       timers_irq_ctrl_tf2_set_i,
  input  logic       timers_irq_ctrl_sfr_wr_tcon_i,
  input  logic       timers_irq_ctrl_sfr_wr_tcon2_i,
  input  logic       timers_irq_ctrl_sfr_tf0_i,
  input  logic       timers_irq_ctrl_sfr_tf1_i,
  input  logic       timers_irq_ctrl_sfr_tf2_i,
  input  logic       timers_irq_ctrl_ea_i,
  input  logic       timers_irq_ctrl_et0_i,
  input  logic       timers_irq_ctrl_et1_i,
  input  logic       timers_irq_ctrl_et2_i,
  input  logic       timers_irq_ctrl_pt0_i,
  input  logic       timers_irq_ctrl_pt1_i,
  input  logic       timers_irq_ctrl_pt2_i,
  input  logic       timers_irq_ctrl_ack_i,
  input  logic       timers_irq_ctrl_reti_i,
  output logic       timers_irq_ctrl_tf0_o,
  output logic       timers_irq_ctrl_tf1_o,
  output logic       timers_irq_ctrl_tf2_o,
  output logic       timers_irq_ctrl_irq_req_o,
  output logic [1:0] timers_irq_ctrl_vector_o,
  output logic       timers_irq_ctrl_in_service_o
);

  logic       clk;
  logic       rst_n;
  logic       mc_q;
  logic       tick;
  logic       tf0_q, tf1_q, tf2_q;
  logic       tf0_d, tf1_d, tf2_d;
  logic [2:0] pend;
  logic [2:0] prio;
  logic       enc_valid;
  logic [1:0] enc_vector;
  logic       ack_take;
  logic       clr_tf0, clr_tf1;

  irq_state_t state;
  logic       irq_req_q;
  logic [1:0] vector_q;
  logic       in_svc_q;

  assign clk   = timers_irq_ctrl_clock_i;
  assign rst_n = timers_irq_ctrl_reset_i;

  assign tick = timers_irq_ctrl_machine_cycle_i & ~mc_q;

  assign pend = {tf2_q & timers_irq_ctrl_et2_i,
                 tf1_q & timers_irq_ctrl_et1_i,
                 tf0_q & timers_irq_ctrl_et0_i} & {3{timers_irq_ctrl_ea_i}};
  assign prio = {timers_irq_ctrl_pt2_i, timers_irq_ctrl_pt1_i, timers_irq_ctrl_pt0_i};

  // Acceptance of a request clears the granted TF0/TF1 flag; TF2 is left for
  // software because the handler must inspect the timer-2 cause bits first.
  assign ack_take = (state == ST_REQ) & timers_irq_ctrl_ack_i;
  assign clr_tf0  = ack_take & (vector_q == VEC_TF0);
  assign clr_tf1  = ack_take & (vector_q == VEC_TF1);

  timers_irq_prio_enc u_prio_enc (
    .pend   (pend),
    .prio   (prio),
    .valid  (enc_valid),
    .vector (enc_vector)
  );

  // Flag update: an overflow pulse always wins so no overflow is ever lost,
  // then the hardware clear on acceptance, then the software write.
  always_comb begin
    tf0_d = tf0_q;
    if (timers_irq_ctrl_tf0_set_i)          tf0_d = 1'b1;
    else if (clr_tf0)                       tf0_d = 1'b0;
    else if (timers_irq_ctrl_sfr_wr_tcon_i) tf0_d = timers_irq_ctrl_sfr_tf0_i;

    tf1_d = tf1_q;
    if (timers_irq_ctrl_tf1_set_i)          tf1_d = 1'b1;
    else if (clr_tf1)                       tf1_d = 1'b0;
    else if (timers_irq_ctrl_sfr_wr_tcon_i) tf1_d = timers_irq_ctrl_sfr_tf1_i;

    tf2_d = tf2_q;
    if (timers_irq_ctrl_tf2_set_i)           tf2_d = 1'b1;
    else if (timers_irq_ctrl_sfr_wr_tcon2_i) tf2_d = timers_irq_ctrl_sfr_tf2_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q  <= 1'b0;
      tf0_q <= 1'b0;
      tf1_q <= 1'b0;
      tf2_q <= 1'b0;
    end else begin
      mc_q  <= timers_irq_ctrl_machine_cycle_i;
      tf0_q <= tf0_d;
      tf1_q <= tf1_d;
      tf2_q <= tf2_d;
    end
  end

  // Request FSM with registered outputs. The vector is captured once on entry
  // to REQ and held; only a loss of the granted source or an ack leaves REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      irq_req_q <= 1'b0;
      vector_q  <= VEC_NONE;
      in_svc_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick && enc_valid) begin
            state     <= ST_REQ;
            irq_req_q <= 1'b1;
            vector_q  <= enc_vector;
          end
        end
        ST_REQ: begin
          if (timers_irq_ctrl_ack_i) begin
            state     <= ST_SVC;
            irq_req_q <= 1'b0;
            vector_q  <= VEC_NONE;
            in_svc_q  <= 1'b1;
          end else if (!vec_pending(vector_q, pend)) begin
            state     <= ST_IDLE;
            irq_req_q <= 1'b0;
            vector_q  <= VEC_NONE;
          end
        end
        ST_SVC: begin
          if (timers_irq_ctrl_reti_i) begin
            state    <= ST_IDLE;
            in_svc_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          irq_req_q <= 1'b0;
          vector_q  <= VEC_NONE;
          in_svc_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timers_irq_ctrl_tf0_o        = tf0_q;
  assign timers_irq_ctrl_tf1_o        = tf1_q;
  assign timers_irq_ctrl_tf2_o        = tf2_q;
  assign timers_irq_ctrl_irq_req_o    = irq_req_q;
  assign timers_irq_ctrl_vector_o     = vector_q;
  assign timers_irq_ctrl_in_service_o = in_svc_q;

endmodule

// File: tb/tb_timers_irq_ctrl.sv
// Testbench for timers_irq_ctrl: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the controller.
module tb_timers_irq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mc = 1'b0;
  logic set0 = 1'b0, set1 = 1'b0, set2 = 1'b0;
  logic wr_tcon = 1'b0, wr_tcon2 = 1'b0;
  logic sd0 = 1'b0, sd1 = 1'b0, sd2 = 1'b0;
  logic ea = 1'b0, et0 = 1'b0, et1 = 1'b0, et2 = 1'b0;
  logic pt0 = 1'b0, pt1 = 1'b0, pt2 = 1'b0;
  logic ack = 1'b0, reti = 1'b0;

  logic       o_tf0, o_tf1, o_tf2, o_irq, o_svc;
  logic [1:0] o_vec;

  int tests = 0;
  int fails = 0;

  // Behavioural model state: flags, phase (0 idle, 1 requesting, 2 in service)
  bit         m_tf[3];
  int         m_ph;
  bit         m_req;
  logic [1:0] m_vec;
  bit         m_svc;
  bit         m_mc;

  always #5 clk = ~clk;

  timers_irq_ctrl dut (
    .timers_irq_ctrl_clock_i         (clk),
    .timers_irq_ctrl_reset_i         (rst_n),
    .timers_irq_ctrl_machine_cycle_i (mc),
    .timers_irq_ctrl_tf0_set_i       (set0),
    .timers_irq_ctrl_tf1_set_i       (set1),
    .timers_irq_ctrl_tf2_set_i       (set2),
    .timers_irq_ctrl_sfr_wr_tcon_i   (wr_tcon),
    .timers_irq_ctrl_sfr_wr_tcon2_i  (wr_tcon2),
    .timers_irq_ctrl_sfr_tf0_i       (sd0),
    .timers_irq_ctrl_sfr_tf1_i       (sd1),
    .timers_irq_ctrl_sfr_tf2_i       (sd2),
    .timers_irq_ctrl_ea_i            (ea),
    .timers_irq_ctrl_et0_i           (et0),
    .timers_irq_ctrl_et1_i           (et1),
    .timers_irq_ctrl_et2_i           (et2),
    .timers_irq_ctrl_pt0_i           (pt0),
    .timers_irq_ctrl_pt1_i           (pt1),
    .timers_irq_ctrl_pt2_i           (pt2),
    .timers_irq_ctrl_ack_i           (ack),
    .timers_irq_ctrl_reti_i          (reti),
    .timers_irq_ctrl_tf0_o           (o_tf0),
    .timers_irq_ctrl_tf1_o           (o_tf1),
    .timers_irq_ctrl_tf2_o           (o_tf2),
    .timers_irq_ctrl_irq_req_o       (o_irq),
    .timers_irq_ctrl_vector_o        (o_vec),
    .timers_irq_ctrl_in_service_o    (o_svc)
  );

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tf[i] = 1'b0;
    m_ph = 0; m_req = 1'b0; m_vec = 2'b00; m_svc = 1'b0; m_mc = 1'b0;
  endtask

  // One clock of the controller's rules, applied to the inputs now on the pins.
  task automatic model_step();
    bit s[3], wr[3], d[3], en[3], pr[3], pend[3], nf[3];
    bit tick;
    int best, best_score, score;
    s  = '{set0, set1, set2};
    wr = '{wr_tcon, wr_tcon, wr_tcon2};
    d  = '{sd0, sd1, sd2};
    en = '{et0, et1, et2};
    pr = '{pt0, pt1, pt2};
    tick = mc && !m_mc;
    for (int i = 0; i < 3; i++) pend[i] = m_tf[i] && en[i] && ea;
    for (int i = 0; i < 3; i++) begin
      if (s[i]) nf[i] = 1'b1;
      else if (i < 2 && m_ph == 1 && ack && int'(m_vec) == i + 1) nf[i] = 1'b0;
      else if (wr[i]) nf[i] = d[i];
      else nf[i] = m_tf[i];
    end
    case (m_ph)
      0: if (tick) begin
        best = -1; best_score = -1;
        for (int i = 0; i < 3; i++) begin
          score = (pr[i] ? 10 : 0) + (2 - i);
          if (pend[i] && score > best_score) begin best = i; best_score = score; end
        end
        if (best >= 0) begin m_ph = 1; m_req = 1'b1; m_vec = 2'(best + 1); end
      end
      1: if (ack) begin
        m_ph = 2; m_req = 1'b0; m_vec = 2'b00; m_svc = 1'b1;
      end else if (!pend[int'(m_vec) - 1]) begin
        m_ph = 0; m_req = 1'b0; m_vec = 2'b00;
      end
      default: if (reti) begin m_ph = 0; m_svc = 1'b0; end
    endcase
    for (int i = 0; i < 3; i++) m_tf[i] = nf[i];
    m_mc = mc;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    set0 = 0; set1 = 0; set2 = 0; wr_tcon = 0; wr_tcon2 = 0; ack = 0; reti = 0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    tests++;
    if ({o_tf2, o_tf1, o_tf0, o_irq, o_vec, o_svc} !== 7'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 0000000", {o_tf2, o_tf1, o_tf0, o_irq, o_vec, o_svc});
    end
    #3 rst_n = 1'b1;
    step();
    tests++;
    if ({o_irq, o_vec, o_svc} !== 4'b0) begin
      fails++; $display("FAIL reset_idle_after_release: got %b want 0000", {o_irq, o_vec, o_svc});
    end
  endtask

  task automatic test_basic_tf0();
    ea = 1; et0 = 1;
    set0 = 1; step(); clear_pulses();
    tests++;
    if ({o_tf0, o_irq} !== 2'b10) begin
      fails++; $display("FAIL basic_set_no_tick: got tf0/irq=%b want 10", {o_tf0, o_irq});
    end
    mc = 1; step(); mc = 0;
    tests++;
    if ({o_irq, o_vec} !== 3'b101) begin
      fails++; $display("FAIL basic_request: got irq/vec=%b want 101", {o_irq, o_vec});
    end
    ack = 1; step(); clear_pulses();
    tests++;
    if ({o_tf0, o_irq, o_svc} !== 3'b001) begin
      fails++; $display("FAIL basic_ack: got tf0/irq/svc=%b want 001", {o_tf0, o_irq, o_svc});
    end
    reti = 1; step(); clear_pulses();
    tests++;
    if ({o_svc, o_vec} !== 3'b000) begin
      fails++; $display("FAIL basic_reti: got svc/vec=%b want 000", {o_svc, o_vec});
    end
  endtask

  task automatic test_priority();
    et1 = 1; pt1 = 1; pt0 = 0;
    set0 = 1; set1 = 1; step(); clear_pulses();
    mc = 1; step(); mc = 0;
    tests++;
    if ({o_irq, o_vec} !== 3'b110) begin
      fails++; $display("FAIL prio_high_tf1: got irq/vec=%b want 110", {o_irq, o_vec});
    end
    ack = 1; step(); clear_pulses();
    tests++;
    if ({o_tf0, o_tf1, o_svc} !== 3'b101) begin
      fails++; $display("FAIL prio_ack_keeps_tf0: got tf0/tf1/svc=%b want 101", {o_tf0, o_tf1, o_svc});
    end
    reti = 1; step(); clear_pulses();
    wr_tcon = 1; sd0 = 0; sd1 = 0; step(); clear_pulses();
    tests++;
    if (o_tf0 !== 1'b0) begin
      fails++; $display("FAIL prio_sw_clear_tf0: got %b want 0", o_tf0);
    end
    pt1 = 0;
  endtask

  task automatic test_tf2();
    et2 = 1;
    set2 = 1; step(); clear_pulses();
    mc = 1; step(); mc = 0;
    tests++;
    if ({o_irq, o_vec} !== 3'b111) begin
      fails++; $display("FAIL tf2_request: got irq/vec=%b want 111", {o_irq, o_vec});
    end
    ack = 1; step(); clear_pulses();
    tests++;
    if ({o_tf2, o_svc} !== 2'b11) begin
      fails++; $display("FAIL tf2_ack_keeps_flag: got tf2/svc=%b want 11", {o_tf2, o_svc});
    end
    reti = 1; step(); clear_pulses();
    wr_tcon2 = 1; sd2 = 0; step(); clear_pulses();
    tests++;
    if (o_tf2 !== 1'b0) begin
      fails++; $display("FAIL tf2_sw_clear: got %b want 0", o_tf2);
    end
  endtask

  task automatic test_withdraw();
    set1 = 1; step(); clear_pulses();
    mc = 1; step(); mc = 0;
    tests++;
    if ({o_irq, o_vec} !== 3'b110) begin
      fails++; $display("FAIL withdraw_request: got irq/vec=%b want 110", {o_irq, o_vec});
    end
    wr_tcon = 1; sd0 = 0; sd1 = 0; step(); clear_pulses();
    tests++;
    if (o_tf1 !== 1'b0) begin
      fails++; $display("FAIL withdraw_flag_cleared: got %b want 0", o_tf1);
    end
    step();
    tests++;
    if ({o_irq, o_vec, o_svc} !== 4'b0000) begin
      fails++; $display("FAIL withdraw_idle: got irq/vec/svc=%b want 0000", {o_irq, o_vec, o_svc});
    end
  endtask

  task automatic test_set_collisions();
    wr_tcon = 1; sd0 = 0; sd1 = 0; set0 = 1; step(); clear_pulses();
    tests++;
    if (o_tf0 !== 1'b1) begin
      fails++; $display("FAIL set_beats_write: got %b want 1", o_tf0);
    end
    mc = 1; step(); mc = 0;
    tests++;
    if ({o_irq, o_vec} !== 3'b101) begin
      fails++; $display("FAIL collision_request: got irq/vec=%b want 101", {o_irq, o_vec});
    end
    ack = 1; set0 = 1; step(); clear_pulses();
    tests++;
    if ({o_tf0, o_svc} !== 2'b11) begin
      fails++; $display("FAIL set_beats_ack_clear: got tf0/svc=%b want 11", {o_tf0, o_svc});
    end
    reti = 1; step(); clear_pulses();
    wr_tcon = 1; sd0 = 0; step(); clear_pulses();
  endtask

  task automatic test_reset_in_service();
    set0 = 1; step(); clear_pulses();
    mc = 1; step(); mc = 0;
    ack = 1; step(); clear_pulses();
    tests++;
    if (o_svc !== 1'b1) begin
      fails++; $display("FAIL rst_svc_entered: got %b want 1", o_svc);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({o_tf2, o_tf1, o_tf0, o_irq, o_vec, o_svc} !== 7'b0) begin
      fails++; $display("FAIL rst_immediate: got %b want 0000000", {o_tf2, o_tf1, o_tf0, o_irq, o_vec, o_svc});
    end
    #3 rst_n = 1'b1;
    set0 = 1; step(); clear_pulses();
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (o_irq !== 1'b0) begin
        fails++; $display("FAIL rst_no_req_before_tick: cycle %0d got %b want 0", k, o_irq);
      end
      step();
    end
    mc = 1; step(); mc = 0;
    tests++;
    if ({o_irq, o_vec} !== 3'b101) begin
      fails++; $display("FAIL rst_req_after_tick: got irq/vec=%b want 101", {o_irq, o_vec});
    end
    ack = 1; step(); clear_pulses();
    reti = 1; step(); clear_pulses();
  endtask

  task automatic test_random();
    logic [6:0] exp_v, got_v;
    for (int c = 0; c < 600; c++) begin
      mc   = 1'($urandom_range(0, 1));
      set0 = ($urandom_range(0, 7) == 0);
      set1 = ($urandom_range(0, 7) == 0);
      set2 = ($urandom_range(0, 9) == 0);
      wr_tcon  = ($urandom_range(0, 9) == 0);
      wr_tcon2 = ($urandom_range(0, 11) == 0);
      sd0 = 1'($urandom_range(0, 1)); sd1 = 1'($urandom_range(0, 1)); sd2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        ea  = ($urandom_range(0, 7) != 0);
        et0 = 1'($urandom_range(0, 1)); et1 = 1'($urandom_range(0, 1)); et2 = 1'($urandom_range(0, 1));
        pt0 = 1'($urandom_range(0, 1)); pt1 = 1'($urandom_range(0, 1)); pt2 = 1'($urandom_range(0, 1));
      end
      ack  = ($urandom_range(0, 2) == 0);
      reti = ($urandom_range(0, 3) == 0);
      step();
      exp_v = {m_tf[2], m_tf[1], m_tf[0], m_req, m_vec, m_svc};
      got_v = {o_tf2, o_tf1, o_tf0, o_irq, o_vec, o_svc};
      tests++;
      if (got_v !== exp_v) begin
        fails++; $display("FAIL random_cycle_%0d: got tf210/irq/vec/svc=%b want %b", c, got_v, exp_v);
      end
    end
    clear_pulses();
    mc = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_tf0();
    test_priority();
    test_tf2();
    test_withdraw();
    test_set_collisions();
    test_reset_in_service();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
